// File: rtl/load_data_align_if.sv
// Load-return bus between the EX/MEM pipeline control, the data memory and the
// writeback-facing aligned result.
interface load_data_align_if;
  logic        stall;
  logic        flush;
  logic        ld_valid_in;
  logic [2:0]  ld_funct3;
  logic [31:0] address;
  logic [4:0]  rd_in;
  logic [31:0] mem_rdata;
  logic        ld_valid_out;
  logic [31:0] ld_data_out;
  logic [4:0]  rd_out;
  logic        misaligned;

  // Pipeline/memory side driving requests and consuming results
  modport master (
    output stall, flush, ld_valid_in, ld_funct3, address, rd_in, mem_rdata,
    input  ld_valid_out, ld_data_out, rd_out, misaligned
  );

  // Alignment block
  modport slave (
    input  stall, flush, ld_valid_in, ld_funct3, address, rd_in, mem_rdata,
    output ld_valid_out, ld_data_out, rd_out, misaligned
  );
endinterface

// File: rtl/load_data_align.sv
// Load-return alignment: tracks one in-flight load across the synchronous-read
// memory, buffers the word on stall, and registers the extended result.
// Optional LOAD_MISALIGN_TRAP_EN registers a misalignment flag with the result.
module load_data_align (
  input logic           clk,
  input logic           rst,
  load_data_align_if.slave bus
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned OFF_W = 2;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HELD = 2'd2
  } state_t;

  typedef struct packed {
    logic [OFF_W-1:0] offset;
    logic [F3_W-1:0]  funct3;
    logic [REG_W-1:0] rd;
  } req_t;

  state_t           state_q;
  state_t           state_d;
  req_t             req_q;
  logic [XLEN-1:0]  hold_q;
  logic             valid_q;
  logic [XLEN-1:0]  data_q;
  logic [REG_W-1:0] rd_q;

  logic             accept_c;
  logic             produce_c;
  logic             hold_load_c;
  logic [XLEN-1:0]  src_word_c;
  logic [XLEN-1:0]  result_c;

  // Upper address bits are irrelevant to a word-wide memory return
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.address[XLEN-1:OFF_W];

  // Byte/halfword/word extraction with sign or zero extension
  function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0]  word,
                                            input logic [OFF_W-1:0] off,
                                            input logic [F3_W-1:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   align = {{24{b[7]}}, b};
      F3_LBU:  align = {24'h000000, b};
      F3_LH:   align = {{16{h[15]}}, h};
      F3_LHU:  align = {16'h0000, h};
      F3_LW:   align = word;
      default: align = '0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, result production and hold-buffer capture
  always_comb begin
    state_d     = state_q;
    produce_c   = 1'b0;
    hold_load_c = 1'b0;
    src_word_c  = bus.mem_rdata;
    accept_c    = bus.ld_valid_in & ~bus.stall & ~bus.flush;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) state_d = WAIT;
        end
        WAIT: begin
          if (bus.stall) begin
            hold_load_c = 1'b1;
            state_d     = HELD;
          end else begin
            produce_c  = 1'b1;
            src_word_c = bus.mem_rdata;
            state_d    = accept_c ? WAIT : IDLE;
          end
        end
        HELD: begin
          if (!bus.stall) begin
            produce_c  = 1'b1;
            src_word_c = hold_q;
            state_d    = accept_c ? WAIT : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign result_c = align(src_word_c, req_q.offset, req_q.funct3);

  // Request metadata, hold buffer and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      rd_q    <= '0;
    end else begin
      if (hold_load_c) hold_q <= bus.mem_rdata;
      if (accept_c) begin
        req_q.offset <= bus.address[OFF_W-1:0];
        req_q.funct3 <= bus.ld_funct3;
        req_q.rd     <= bus.rd_in;
      end
      if (!bus.stall) begin
        valid_q <= produce_c;
        if (produce_c) begin
          data_q <= result_c;
          rd_q   <= req_q.rd;
        end
      end
    end
  end

  assign bus.ld_valid_out = valid_q;
  assign bus.ld_data_out  = data_q;
  assign bus.rd_out       = rd_q;

`ifdef LOAD_MISALIGN_TRAP_EN
  logic mis_q;
  logic mis_c;

  // Halfword needs an even offset, word needs offset zero
  always_comb begin
    mis_c = 1'b0;
    case (req_q.funct3)
      F3_LH, F3_LHU: mis_c = req_q.offset[0];
      F3_LW:         mis_c = |req_q.offset;
      default:       mis_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                          mis_q <= 1'b0;
    else if (!bus.stall && produce_c) mis_q <= mis_c;
  end

  assign bus.misaligned = mis_q;
`else
  assign bus.misaligned = 1'b0;
`endif

endmodule

// File: doc/load_data_align.md
# load_data_align

Load-return path of the EX/MEM stage, the read-side counterpart to the store write-enable alignment logic. It accepts a load request (funct3, byte address, destination register) in the issue cycle and tracks it while the synchronous-read memory returns the full 32-bit word one cycle later. It extracts and sign- or zero-extends the addressed byte, halfword or word. It presents the result, registered, to writeback, and buffers the returned word when the pipeline stalls in the data-return cycle.

## Interface
Parameters:
- none

Ports:
- clk  in  1  core clock; every register updates on the rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  pipeline freeze; blocks acceptance and holds all outputs
- flush  in  1  kills the in-flight request (pending or buffered)
- ld_valid_in  in  1  load request present this cycle
- ld_funct3  in  3  RV32I load funct3
- address  in  32  byte address of the load; only [1:0] is used
- rd_in  in  5  destination register
- mem_rdata  in  32  memory read word; valid only in the cycle after acceptance
- ld_valid_out  out  1  aligned result valid
- ld_data_out  out  32  aligned, extended load data
- rd_out  out  5  destination register of the result
- misaligned  out  1  misalignment flag for the result (see Configuration)

## Operation
- Request register: {offset = address[1:0], funct3, rd}, plus a state machine:
  - IDLE: nothing in flight.
  - WAIT: mem_rdata carries the data for the request this cycle.
  - HELD: the data word is in the 32-bit hold buffer.
- Accept: a request is accepted when ld_valid_in=1, stall=0 and flush=0. On acceptance, the metadata is captured and the state goes to WAIT.
- IDLE:
  - accept → WAIT
  - otherwise stay in IDLE
- WAIT, stall=0:
  - output register loads align(mem_rdata); ld_valid_out=1
  - next state is WAIT on a new accept, otherwise IDLE
  - back-to-back loads therefore sustain one per cycle
- WAIT, stall=1:
  - hold buffer captures mem_rdata → HELD
  - outputs are unchanged
- HELD, stall=0:
  - output register loads align(hold buffer); ld_valid_out=1
  - next state is WAIT on a new accept, otherwise IDLE
- HELD, stall=1: remain in HELD; the buffer does not reload.
- Output valid drop: when stall=0 and no aligned result is produced this cycle, ld_valid_out goes to 0. ld_data_out and rd_out keep their last values.
- flush:
  - state goes to IDLE and the pending request is discarded
  - the output register is not loaded that cycle, so ld_valid_out goes to 0 unless stall=1
  - flush has priority over stall and over ld_valid_in
- Alignment:
  - funct3 000 (LB): byte[offset], sign-extended
  - funct3 100 (LBU): byte[offset], zero-extended
  - funct3 001 (LH): halfword[offset[1]], sign-extended; offset[0] is ignored, so 01 behaves as 00 and 11 as 10
  - funct3 101 (LHU): same halfword selection, zero-extended
  - funct3 010 (LW): the whole word, with offset ignored
  - Reserved funct3 (011, 110, 111): data is 0x00000000 and ld_valid_out is still asserted.
- Byte numbering: byte n = word[8n+7:8n]; halfword 0 = [15:0], halfword 1 = [31:16].

## Timing
- Latency: a request accepted at edge N has its result visible from edge N+2, provided no stall occurs. Each stall cycle adds one cycle.
- Reset values: state IDLE, ld_valid_out 0, ld_data_out 0x00000000, rd_out 0, misaligned 0, hold buffer 0.
- Reset asserted mid-operation discards all in-flight state at the next edge.
- All outputs are registered; none depends combinationally on any input.

## Configuration
- LOAD_MISALIGN_TRAP_EN defined:
  - misaligned is registered alongside ld_data_out
  - it is 1 for LH/LHU with offset[0]=1, and for LW with offset≠0
  - data alignment is unchanged (misaligned data is still delivered)
- LOAD_MISALIGN_TRAP_EN undefined: the misaligned port exists but is constant 0, and no check logic is present.

## Test plan
All cases use mem_rdata = 0x80F17F02.
- LB, address 0x...03, rd=5 → at N+2: ld_valid_out=1, ld_data_out=0xFFFFFF80, rd_out=5. LBU at the same address → 0x00000080.
- LH at offset 2 → 0xFFFF80F1; LHU at offset 2 → 0x000080F1; LH at offset 1 → 0x00007F02; LW at offset 0 → 0x80F17F02.
- Stall held for 3 cycles starting in the WAIT cycle, with mem_rdata changed to 0xDEADBEEF during the stall. Required after release: ld_data_out reflects 0x80F17F02, and ld_valid_out rises exactly one cycle after stall falls.
- Three back-to-back LW at offset 0 (rd 1, 2, 3) with no stall → ld_valid_out high for 3 consecutive cycles, with rd_out sequence 1, 2, 3.
- flush asserted in the WAIT cycle → ld_valid_out stays 0 and no result is delivered. flush together with ld_valid_in → that request is never delivered.
- LOAD_MISALIGN_TRAP_EN defined:
  - LW at offset 1 → misaligned=1 with ld_data_out=0x80F17F02
  - LH at offset 2 → misaligned=0
  - macro undefined: misaligned=0 in both cases
